// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters and sequencing each transaction.
// Optional bus-hang watchdog and its wd_fired output are enabled with `define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [NUM_REQ*9-1:0] req_dev_addr,
    input  logic [NUM_REQ*8-1:0] req_reg_addr,
    input  logic [NUM_REQ*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_grant,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic [8:0]           i2c_device_address,
    output logic [7:0]           i2c_reg_address,
    output logic [7:0]           i2c_data_in,
    output logic                 i2c_rw,
    output logic                 i2c_start,
    input  logic [7:0]           i2c_data_out,
    input  logic [1:0]           i2c_status,
    output logic                 busy,
`ifdef I2C_ARB_TIMEOUT_EN
    output logic                 wd_fired,
`endif
    output logic [2:0]           dbg_state
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Handshake: req_valid[i] is held until req_grant[i] pulses; fields are latched in the
    // grant cycle, so the requester may drop or change them afterwards. rsp_valid[i] is a
    // one-cycle pulse and rsp_rdata/rsp_err hold their value until the next response.

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [8:0]      dev_q, dev_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            rw_q, rw_d;
    logic            start_q, start_d;
    logic            wd_hit;

    // Requester selection: first valid at or after rr_ptr, wrapping.
    logic            found;
    logic [IW-1:0]   sel_idx;
    logic [IW:0]     sum;
    logic [IW-1:0]   next_ptr;
    logic            sel_rw;
    logic [8:0]      sel_dev;
    logic [7:0]      sel_reg;
    logic [7:0]      sel_wdata;

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        sum     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            if (!found && req_valid[sum[IW-1:0]]) begin
                found   = 1'b1;
                sel_idx = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_rw    = 1'b0;
        sel_dev   = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == sel_idx) begin
                sel_rw    = req_rw[i];
                sel_dev   = req_dev_addr[9*i +: 9];
                sel_reg   = req_reg_addr[8*i +: 8];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
        next_ptr = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + IW'(1);
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        wd_fired_q, wd_fired_d;
    assign wd_hit   = (wd_cnt_q == 16'(TIMEOUT_CYC));
    assign wd_fired = wd_fired_q;
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        grant_d     = '0;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        start_d     = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
        wd_fired_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d          = ISSUE;
                    win_d            = sel_idx;
                    grant_d[sel_idx] = 1'b1;
                    rr_ptr_d         = next_ptr;
                    rw_d             = sel_rw;
                    dev_d            = sel_dev;
                    reg_d            = sel_reg;
                    wdata_d          = sel_wdata;
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                state_d = WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (i2c_status[1]) begin
                    // Done (ACK or NACK), possibly without ever reporting busy.
                    state_d            = RESP;
                    rsp_valid_d[win_q] = 1'b1;
                    rdata_d            = rw_q ? i2c_data_out : 8'h00;
                    err_d              = i2c_status[0];
                end else if (wd_hit) begin
                    state_d            = RESP;
                    rsp_valid_d[win_q] = 1'b1;
                    rdata_d            = 8'h00;
                    err_d              = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_fired_d         = 1'b1;
`endif
                end else begin
                    if (state_q == WAIT_BUSY && i2c_status == 2'b01) begin
                        state_d = WAIT_DONE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_cnt_d = wd_cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            start_q     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt_q    <= '0;
            wd_fired_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            grant_q     <= grant_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            start_q     <= start_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt_q    <= wd_cnt_d;
            wd_fired_q  <= wd_fired_d;
`endif
        end
    end

    assign req_grant          = grant_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rdata_q;
    assign rsp_err            = err_q;
    assign i2c_device_address = dev_q;
    assign i2c_reg_address    = reg_q;
    assign i2c_data_in        = wdata_q;
    assign i2c_rw             = rw_q;
    assign i2c_start          = start_q;
    assign busy               = (state_q != IDLE);
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: directed transactions against a scripted I2C master model.
// Build with I2C_ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT_CYC=20).
module tb_i2c_bus_arbiter;

    localparam int NUM_REQ = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_rw;
    logic [17:0]  req_dev_addr;
    logic [15:0]  req_reg_addr, req_wdata;
    logic [1:0]   req_grant, rsp_valid;
    logic [7:0]   rsp_rdata;
    logic         rsp_err;
    logic [8:0]   i2c_device_address;
    logic [7:0]   i2c_reg_address, i2c_data_in, i2c_data_out;
    logic         i2c_rw, i2c_start, busy;
    logic [1:0]   i2c_status;
    logic [2:0]   dbg_state;
`ifdef I2C_ARB_TIMEOUT_EN
    logic         wd_fired;
`endif

    i2c_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .i2c_device_address(i2c_device_address), .i2c_reg_address(i2c_reg_address),
        .i2c_data_in(i2c_data_in), .i2c_rw(i2c_rw), .i2c_start(i2c_start),
        .i2c_data_out(i2c_data_out), .i2c_status(i2c_status), .busy(busy),
`ifdef I2C_ARB_TIMEOUT_EN
        .wd_fired(wd_fired),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: exp entry = {timeout, wd, idx[2:0], err, rdata[7:0]}
    int           n_chk = 0;
    int           n_err = 0;
    logic [13:0]  exp_q[$];
    int           g_q[$];
    logic [25:0]  bus_q[$];
    int           m_nb_q[$];
    logic [1:0]   m_fin_q[$];
    logic [7:0]   m_do_q[$];
    logic         m_kill = 1'b0;
    int           grant_cyc = 0, start_cyc = 0, done_cyc = 0;
    logic [25:0]  cur_bus = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int idx, input logic rw, input logic [8:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
        req_rw[idx]              = rw;
        req_dev_addr[9*idx +: 9] = dev;
        req_reg_addr[8*idx +: 8] = rg;
        req_wdata[8*idx +: 8]    = wd;
    endtask

    task automatic expect_txn(input int idx, input logic rw, input logic [8:0] dev,
                              input logic [7:0] rg, input logic [7:0] wd, input int nb,
                              input logic [1:0] fin, input logic [7:0] dout,
                              input bit has_rsp, input bit tmo);
        logic       e_err;
        logic [7:0] e_rdata;
        g_q.push_back(idx);
        bus_q.push_back({rw, dev, rg, wd});
        m_nb_q.push_back(nb);
        m_fin_q.push_back(fin);
        m_do_q.push_back(dout);
        e_err   = tmo ? 1'b1 : (fin == 2'b11);
        e_rdata = (rw && !tmo) ? dout : 8'h00;
        if (has_rsp) exp_q.push_back({tmo, tmo, 3'(idx), e_err, e_rdata});
    endtask

    task automatic raise(input logic [1:0] v);
        @(posedge clk);
        #1;
        req_valid = v;
    endtask

    task automatic wait_grant();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_grant != 2'b00) break;
        end
        if (k == 200) chk("grant_timeout", 32'(req_grant), 32'h1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        if (k == 400) chk("idle_timeout", 32'(exp_q.size()), 32'h0);
    endtask

    // scripted I2C master: busy for nb cycles, then one cycle of final status
    initial begin
        int         nb;
        logic [1:0] fin;
        logic [7:0] dout;
        bit         aborted;
        i2c_status   = 2'b00;
        i2c_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (i2c_start && m_nb_q.size() > 0) begin
                nb      = m_nb_q.pop_front();
                fin     = m_fin_q.pop_front();
                dout    = m_do_q.pop_front();
                m_kill  = 1'b0;
                aborted = 1'b0;
                for (int k = 0; k < nb; k++) begin
                    @(posedge clk);
                    #1;
                    if (!reset || m_kill) begin
                        aborted = 1'b1;
                        break;
                    end
                    i2c_status = 2'b01;
                end
                if (!aborted) begin
                    @(posedge clk);
                    #1;
                    i2c_status   = fin;
                    i2c_data_out = dout;
                    done_cyc     = cyc;
                    @(posedge clk);
                    #1;
                end
                i2c_status = 2'b00;
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents grant, start or response
    always @(negedge clk) begin
        int          e_idx;
        logic [13:0] e;
        if (req_grant != 2'b00) begin
            if (g_q.size() == 0) chk("grant_unexpected", 32'(req_grant), 32'h0);
            else begin
                e_idx = g_q.pop_front();
                chk("grant", 32'(req_grant), 32'(1 << e_idx));
                grant_cyc = cyc;
            end
        end
        if (i2c_start) begin
            if (bus_q.size() == 0) chk("start_unexpected", 32'(i2c_start), 32'h0);
            else begin
                cur_bus = bus_q.pop_front();
                chk("bus_at_start", 32'({i2c_rw, i2c_device_address, i2c_reg_address, i2c_data_in}),
                    32'(cur_bus));
                chk("grant_to_start", cyc, grant_cyc + 1);
                start_cyc = cyc;
            end
        end
        if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1 << e[11:9]));
                chk("rsp_err", 32'(rsp_err), 32'(e[8]));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
                chk("bus_hold_resp", 32'({i2c_rw, i2c_device_address, i2c_reg_address, i2c_data_in}),
                    32'(cur_bus));
                if (e[13]) chk("timeout_latency", cyc, start_cyc + 21);
                else       chk("done_to_rsp", cyc, done_cyc + 1);
`ifdef I2C_ARB_TIMEOUT_EN
                chk("wd_fired", 32'(wd_fired), 32'(e[12]));
`endif
            end
        end
    end

    // global time bound
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        req_valid    = 2'b00;
        req_rw       = '0;
        req_dev_addr = '0;
        req_reg_addr = '0;
        req_wdata    = '0;

        // reset held with both requesting: outputs quiet, then requester 0 first
        set_req(0, 1'b0, 9'h034, 8'h0A, 8'h5C);
        set_req(1, 1'b1, 9'h050, 8'h02, 8'h00);
        req_valid = 2'b11;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_grant", 32'(req_grant), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_start", 32'(i2c_start), 32'h0);
            chk("rst_rsp", 32'(rsp_valid), 32'h0);
            chk("rst_dev", 32'(i2c_device_address), 32'h0);
        end
        // single write (data_out non-zero but write reports 0), then read with NACK
        expect_txn(0, 1'b0, 9'h034, 8'h0A, 8'h5C, 10, 2'b10, 8'h3C, 1'b1, 1'b0);
        expect_txn(1, 1'b1, 9'h050, 8'h02, 8'h00, 4,  2'b11, 8'hFF, 1'b1, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("grant_after_release", 32'(req_grant), 32'h1);
        raise(2'b10);
        wait_grant();
        raise(2'b00);
        wait_idle();

        // read with ACK, fast completion (no busy phase)
        expect_txn(1, 1'b1, 9'h050, 8'h02, 8'h00, 0, 2'b10, 8'hA7, 1'b1, 1'b0);
        raise(2'b10);
        wait_grant();
        raise(2'b00);
        wait_idle();

        // round robin: both held for four transactions -> 0,1,0,1
        set_req(0, 1'b0, 9'h1A5, 8'h11, 8'h22);
        set_req(1, 1'b1, 9'h0F0, 8'h33, 8'h44);
        expect_txn(0, 1'b0, 9'h1A5, 8'h11, 8'h22, 2, 2'b10, 8'h55, 1'b1, 1'b0);
        expect_txn(1, 1'b1, 9'h0F0, 8'h33, 8'h44, 1, 2'b10, 8'h66, 1'b1, 1'b0);
        expect_txn(0, 1'b0, 9'h1A5, 8'h11, 8'h22, 0, 2'b11, 8'h77, 1'b1, 1'b0);
        expect_txn(1, 1'b1, 9'h0F0, 8'h33, 8'h44, 3, 2'b10, 8'h88, 1'b1, 1'b0);
        raise(2'b11);
        repeat (4) wait_grant();
        raise(2'b00);
        wait_idle();

        // hung bus on requester 0 (leaves rr_ptr=1), then reset mid-transaction
        set_req(0, 1'b0, 9'h0C3, 8'h5A, 8'hA5);
        expect_txn(0, 1'b0, 9'h0C3, 8'h5A, 8'hA5, 1000, 2'b10, 8'h00, 1'b0, 1'b0);
        raise(2'b01);
        wait_grant();
        raise(2'b00);
`ifdef I2C_ARB_TIMEOUT_EN
        repeat (8) @(negedge clk);
`else
        repeat (60) @(negedge clk);
`endif
        chk("stuck_busy", 32'(busy), 32'h1);
        chk("stuck_state", 32'(dbg_state), 32'h3);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midop_busy", 32'(busy), 32'h0);
        chk("midop_state", 32'(dbg_state), 32'h0);
        chk("midop_rsp", 32'(rsp_valid), 32'h0);
        chk("midop_start", 32'(i2c_start), 32'h0);
        // rr_ptr back to 0: requester 0 wins with both requesting
        set_req(0, 1'b0, 9'h1A5, 8'h11, 8'h22);
        expect_txn(0, 1'b0, 9'h1A5, 8'h11, 8'h22, 2, 2'b10, 8'h99, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 2'b11;
        wait_grant();
        raise(2'b00);
        wait_idle();

`ifdef I2C_ARB_TIMEOUT_EN
        // watchdog: status stuck busy, response 21 cycles after start
        expect_txn(1, 1'b1, 9'h0F0, 8'h33, 8'h44, 1000, 2'b10, 8'h5E, 1'b1, 1'b1);
        raise(2'b10);
        wait_grant();
        raise(2'b00);
        wait_idle();
        m_kill = 1'b1;
        repeat (3) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        chk("leftover_rsp", 32'(exp_q.size()), 32'h0);
        chk("leftover_grant", 32'(g_q.size()), 32'h0);
        chk("leftover_start", 32'(bus_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
